systolic_feed_controller: RTL and testbench
===========================================

# systolic_feed_controller

Sequencer for the systolic skew/data-setup stage that feeds the systolic array. It accepts a job of N input vectors over a valid/ready stream and clears the skew registers before the job. It drives the skew stage's enable so that stalls freeze the diagonal alignment, then pushes zero vectors to drain the skew stage and the array, and finally pulses DONE.

## Interface
- DATA_WIDTH, 8, element width
- SA_LENGTH, 256, array lanes; must be ≥ 2
- MAX_K, 1024, max vectors per job
- DRAIN_EXTRA, 256, extra zero cycles after skew drain so results leave the array; ≥ 0
- CLK  in  1  clock, rising edge
- ASYNC_RST  in  1  asynchronous, active-low reset
- SYNC_RST  in  1  synchronous clear, active-high
- START  in  1  job request, sampled only in IDLE
- NUM_VECTORS  in  $clog2(MAX_K+1)  job length N, sampled with START
- IN_VALID  in  1  upstream vector valid
- IN_READY  out  1  controller accepts vector
- IN_DATA  in  DATA_WIDTH × [SA_LENGTH]  upstream vector
- SETUP_EN  out  1  to skew stage EN
- SETUP_CLR  out  1  to skew stage SYNC_RST
- SETUP_DATA  out  DATA_WIDTH × [SA_LENGTH]  to skew stage Inputs
- BUSY  out  1  job in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: START → CLEAR; latch N.
  - CLEAR: one cycle. If N=0 → DONE, else → FEED.
  - FEED: on the handshake (IN_VALID & IN_READY) where vec_cnt = N−1 → DRAIN, or → DONE if D = 0.
  - DRAIN: D = SA_LENGTH−1+DRAIN_EXTRA cycles, then → DONE.
  - DONE: one cycle, then → IDLE.
- Outputs are combinational from state:
  - IN_READY = (state==FEED).
  - SETUP_EN = (FEED & IN_VALID) | DRAIN.
  - SETUP_DATA = IN_DATA in FEED, all-zero otherwise.
  - SETUP_CLR = SYNC_RST | (state==CLEAR).
  - BUSY = CLEAR|FEED|DRAIN.
  - DONE = (state==DONE).
- vec_cnt increments only on a handshake. drain_cnt increments every DRAIN cycle. Both reset to 0 on entry to CLEAR.
- A FEED cycle without IN_VALID leaves SETUP_EN low, so the skew stage holds and vector alignment is preserved across stalls.
- START outside IDLE (including in the DONE cycle) is ignored. NUM_VECTORS is ignored except with an accepted START.
- N > MAX_K is not legal; the bench must not drive it.
- Counter widths: vec_cnt is $clog2(MAX_K+1). drain_cnt is $clog2(SA_LENGTH+DRAIN_EXTRA) and must not wrap before D.

## Timing
- START accepted at cycle t:
  - CLEAR at t+1.
  - FEED from t+2.
  - The last handshake at cycle f puts DRAIN in f+1 … f+D.
  - DONE at f+D+1; IDLE at f+D+2.
  - With no stalls, f = t+N+1.
- N=0: DONE at t+2.
- Async reset (ASYNC_RST low):
  - Immediately state=IDLE and counters=0.
  - IN_READY=0, SETUP_EN=0, SETUP_CLR=0, BUSY=0, DONE=0, SETUP_DATA=0.
- SYNC_RST (high):
  - Takes effect at the next edge: state=IDLE, counters=0. It overrides START and all transitions.
  - SETUP_CLR is high in the same cycle, so the skew stage clears in lockstep.
  - No DONE is produced for an aborted job.
- No output has extra register latency. Skew-stage lane i output lags SETUP_DATA lane i by i enabled cycles.

## Structure
- Shared package systolic_pkg:
  - feed_state_e enum (IDLE, CLEAR, FEED, DRAIN, DONE).
  - Helper localparams for counter widths.
- One sub-module, systolic_cycle_counter: clear/increment counter with a terminal-match output, instantiated twice (vec_cnt, drain_cnt).
- The FSM stays in the top module.

## Test plan
All scenarios use SA_LENGTH=4, DRAIN_EXTRA=4, so D=7.
- N=3, IN_VALID held 1, START at cycle 0:
  - SETUP_CLR at cycle 1.
  - SETUP_EN and IN_READY cycles 2–4.
  - DRAIN cycles 5–11 with SETUP_DATA=0.
  - DONE at cycle 12, BUSY low from cycle 12.
  - Connected skew stage: lane 3 shows vector 0 at cycle 5.
- N=3 with IN_VALID pattern 1,0,1,0,1 from cycle 2:
  - SETUP_EN only on valid cycles (2, 4, 6).
  - DRAIN cycles 7–13; DONE at cycle 14.
  - Skew outputs identical to the no-stall case apart from the shift.
- N=0:
  - CLEAR at cycle 1, DONE at cycle 2.
  - SETUP_EN and IN_READY never high.
- SYNC_RST at the 3rd DRAIN cycle:
  - SETUP_CLR high that cycle; IDLE next cycle; BUSY=0.
  - DONE never pulses.
  - A new START then runs a full job correctly.
- START pulses during FEED and during the DONE cycle are ignored. START and SYNC_RST in the same IDLE cycle leave the block in IDLE.
- ASYNC_RST low mid-FEED (N=MAX_K):
  - All outputs reach reset values without a clock edge.
  - After release, N=MAX_K completes with exactly MAX_K handshakes.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic feed controller slice.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } feed_state_e;

  localparam int unsigned DEF_SA_LENGTH   = 256;
  localparam int unsigned DEF_MAX_K       = 1024;
  localparam int unsigned DEF_DRAIN_EXTRA = 256;

  function automatic int unsigned vec_cnt_w(input int unsigned max_k);
    return $clog2(max_k + 1);
  endfunction

  // Holds values 0..SA_LENGTH-1+DRAIN_EXTRA, so it never wraps before the drain ends.
  function automatic int unsigned drain_cnt_w(input int unsigned sa_length,
                                              input int unsigned drain_extra);
    int unsigned w;
    w = $clog2(sa_length + drain_extra);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/systolic_cycle_counter.sv
// Clear/increment cycle counter with a terminal-value match flag.
module systolic_cycle_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             match_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == term_i);

endmodule

// File: rtl/systolic_feed_controller.sv
// Sequences one job through the skew stage: clear, feed N vectors, drain with zeros, pulse DONE.
module systolic_feed_controller
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SA_LENGTH   = DEF_SA_LENGTH,
  parameter int unsigned MAX_K       = DEF_MAX_K,
  parameter int unsigned DRAIN_EXTRA = DEF_DRAIN_EXTRA
) (
  input  logic                                 CLK,
  input  logic                                 ASYNC_RST,
  input  logic                                 SYNC_RST,
  input  logic                                 START,
  input  logic [$clog2(MAX_K+1)-1:0]           NUM_VECTORS,
  input  logic                                 IN_VALID,
  output logic                                 IN_READY,
  input  logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] IN_DATA,
  output logic                                 SETUP_EN,
  output logic                                 SETUP_CLR,
  output logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] SETUP_DATA,
  output logic                                 BUSY,
  output logic                                 DONE
);

  localparam int unsigned VW      = vec_cnt_w(MAX_K);
  localparam int unsigned DCW     = drain_cnt_w(SA_LENGTH, DRAIN_EXTRA);
  localparam int unsigned D       = SA_LENGTH - 1 + DRAIN_EXTRA;
  localparam int unsigned D_TERM  = (D == 0) ? 0 : D - 1;

  feed_state_e   state_q, state_d;
  logic [VW-1:0] n_q, n_d;

  logic handshake;
  logic cnt_clr;
  logic vec_last;
  logic drain_last;

  assign handshake = (state_q == S_FEED) && IN_VALID;
  assign cnt_clr   = SYNC_RST || (state_d == S_CLEAR);

  systolic_cycle_counter #(
    .WIDTH (VW)
  ) u_vec_cnt (
    .clk_i   (CLK),
    .rst_ni  (ASYNC_RST),
    .clr_i   (cnt_clr),
    .inc_i   (handshake),
    .term_i  (n_q - VW'(1)),
    .match_o (vec_last)
  );

  systolic_cycle_counter #(
    .WIDTH (DCW)
  ) u_drain_cnt (
    .clk_i   (CLK),
    .rst_ni  (ASYNC_RST),
    .clr_i   (cnt_clr),
    .inc_i   (state_q == S_DRAIN),
    .term_i  (DCW'(D_TERM)),
    .match_o (drain_last)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CLEAR;
          n_d     = NUM_VECTORS;
        end
      end
      S_CLEAR: state_d = (n_q == '0) ? S_DONE : S_FEED;
      S_FEED: begin
        if (handshake && vec_last) begin
          state_d = (D == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Synchronous clear wins over START and every transition, aborting without DONE.
    if (SYNC_RST) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state_q <= S_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    IN_READY   = (state_q == S_FEED);
    SETUP_EN   = handshake || (state_q == S_DRAIN);
    SETUP_DATA = (state_q == S_FEED) ? IN_DATA : '0;
    SETUP_CLR  = SYNC_RST || (state_q == S_CLEAR);
    BUSY       = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);
    DONE       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Directed bench for systolic_feed_controller with SA_LENGTH=4, DRAIN_EXTRA=4 (drain of 7 cycles).
module tb_systolic_feed_controller;

  localparam int unsigned DW  = 8;
  localparam int unsigned SA  = 4;
  localparam int unsigned MK  = 16;
  localparam int unsigned DE  = 4;
  localparam int unsigned NVW = $clog2(MK + 1);

  logic                   CLK = 1'b0;
  logic                   ASYNC_RST;
  logic                   SYNC_RST;
  logic                   START;
  logic [NVW-1:0]         NUM_VECTORS;
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [SA-1:0][DW-1:0]  IN_DATA;
  logic                   SETUP_EN;
  logic                   SETUP_CLR;
  logic [SA-1:0][DW-1:0]  SETUP_DATA;
  logic                   BUSY;
  logic                   DONE;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_feed_controller #(
    .DATA_WIDTH  (DW),
    .SA_LENGTH   (SA),
    .MAX_K       (MK),
    .DRAIN_EXTRA (DE)
  ) dut (
    .CLK         (CLK),
    .ASYNC_RST   (ASYNC_RST),
    .SYNC_RST    (SYNC_RST),
    .START       (START),
    .NUM_VECTORS (NUM_VECTORS),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_DATA     (IN_DATA),
    .SETUP_EN    (SETUP_EN),
    .SETUP_CLR   (SETUP_CLR),
    .SETUP_DATA  (SETUP_DATA),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  always #5 CLK = ~CLK;

  // Lane 3 of a skew stage: three enabled register stages behind SETUP_DATA lane 3.
  logic [DW-1:0] sk3 [3];
  always @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST || SETUP_CLR) begin
      sk3[0] <= '0; sk3[1] <= '0; sk3[2] <= '0;
    end else if (SETUP_EN) begin
      sk3[0] <= SETUP_DATA[3]; sk3[1] <= sk3[0]; sk3[2] <= sk3[1];
    end
  end

  function automatic logic [SA*DW-1:0] vec(input int k);
    return {8'(k*16+4), 8'(k*16+3), 8'(k*16+2), 8'(k*16+1)};
  endfunction

  function automatic logic [DW-1:0] lane3(input int k);
    return 8'(k*16+4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int done_c;
    logic seen_done;

    ASYNC_RST = 1'b0; SYNC_RST = 1'b0; START = 1'b0; NUM_VECTORS = '0;
    IN_VALID = 1'b0; IN_DATA = '0;
    #1;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ready", IN_READY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_data", SETUP_DATA, '0);
    @(posedge CLK); @(posedge CLK); #2;
    ASYNC_RST = 1'b1;
    tick();

    // N=3, IN_VALID held high
    START = 1'b1; NUM_VECTORS = 3; IN_VALID = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      if (c == 1) START = 1'b0;
      IN_DATA = (c >= 2 && c <= 4) ? vec(c-2) : vec(9);
      #1;
      chk("t1_clr", SETUP_CLR, c == 1);
      chk("t1_ready", IN_READY, c >= 2 && c <= 4);
      chk("t1_en", SETUP_EN, c >= 2 && c <= 11);
      chk("t1_done", DONE, c == 12);
      chk("t1_busy", BUSY, c >= 1 && c <= 11);
      if (c >= 2 && c <= 4) chk("t1_data", SETUP_DATA, vec(c-2));
      if (c >= 5 && c <= 11) chk("t1_zero", SETUP_DATA, '0);
      if (c >= 5 && c <= 7) chk("t1_skew3", sk3[2], lane3(c-5));
      tick();
    end

    // N=3, IN_VALID 1,0,1,0,1 from cycle 2
    START = 1'b1; NUM_VECTORS = 3; IN_VALID = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      if (c == 1) START = 1'b0;
      IN_VALID = (c == 2 || c == 4 || c == 6);
      IN_DATA  = (c == 2) ? vec(0) : (c == 4) ? vec(1) : (c == 6) ? vec(2) : vec(14);
      #1;
      chk("t2_ready", IN_READY, c >= 2 && c <= 6);
      chk("t2_en", SETUP_EN, c == 2 || c == 4 || (c >= 6 && c <= 13));
      chk("t2_done", DONE, c == 14);
      chk("t2_busy", BUSY, c >= 1 && c <= 13);
      if (c == 3) chk("t2_stall_data", SETUP_DATA, vec(14));
      if (c >= 7 && c <= 9) chk("t2_skew3", sk3[2], lane3(c-7));
      tick();
    end

    // N=0
    START = 1'b1; NUM_VECTORS = 0; IN_VALID = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c == 1) START = 1'b0;
      #1;
      chk("t3_clr", SETUP_CLR, c == 1);
      chk("t3_done", DONE, c == 2);
      chk("t3_ready", IN_READY, 1'b0);
      chk("t3_en", SETUP_EN, 1'b0);
      tick();
    end

    // SYNC_RST in the 3rd drain cycle (cycle 7)
    START = 1'b1; NUM_VECTORS = 3; IN_VALID = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 1) START = 1'b0;
      IN_DATA = vec(c);
      tick();
    end
    SYNC_RST = 1'b1;
    #1;
    chk("t4_clr", SETUP_CLR, 1'b1);
    chk("t4_busy_pre", BUSY, 1'b1);
    tick();
    SYNC_RST = 1'b0;
    #1;
    chk("t4_busy_post", BUSY, 1'b0);
    chk("t4_en_post", SETUP_EN, 1'b0);
    seen_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (DONE) seen_done = 1'b1;
      tick();
    end
    chk("t4_no_done", seen_done, 1'b0);

    START = 1'b1; SYNC_RST = 1'b1; NUM_VECTORS = 2;
    #1;
    chk("t4_both_clr", SETUP_CLR, 1'b1);
    tick();
    START = 1'b0; SYNC_RST = 1'b0;
    #1;
    chk("t4_both_busy", BUSY, 1'b0);
    chk("t4_both_clr2", SETUP_CLR, 1'b0);
    tick();

    START = 1'b1; NUM_VECTORS = 2;
    for (int c = 0; c <= 12; c++) begin
      if (c == 1) START = 1'b0;
      IN_DATA = vec(c);
      #1;
      chk("t4_job_ready", IN_READY, c >= 2 && c <= 3);
      chk("t4_job_done", DONE, c == 11);
      chk("t4_job_busy", BUSY, c >= 1 && c <= 10);
      tick();
    end

    // START pulses during FEED and DONE are ignored
    START = 1'b1; NUM_VECTORS = 3; IN_VALID = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      START = (c == 0 || c == 3 || c == 14);
      NUM_VECTORS = (c == 0) ? 5'd3 : 5'd5;
      IN_VALID = (c >= 4 && c <= 6);
      IN_DATA = vec(c);
      #1;
      chk("t5_ready", IN_READY, c >= 2 && c <= 6);
      chk("t5_done", DONE, c == 14);
      chk("t5_busy", BUSY, c >= 1 && c <= 13);
      if (c >= 15) chk("t5_clr", SETUP_CLR, 1'b0);
      tick();
    end
    START = 1'b0; IN_VALID = 1'b0;

    // ASYNC_RST mid-FEED with N=MAX_K
    START = 1'b1; NUM_VECTORS = 5'(MK); IN_VALID = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) START = 1'b0;
      IN_DATA = vec(c);
      tick();
    end
    #1;
    ASYNC_RST = 1'b0;
    #1;
    chk("t6_ready", IN_READY, 1'b0);
    chk("t6_en", SETUP_EN, 1'b0);
    chk("t6_clr", SETUP_CLR, 1'b0);
    chk("t6_busy", BUSY, 1'b0);
    chk("t6_done", DONE, 1'b0);
    chk("t6_data", SETUP_DATA, '0);
    @(posedge CLK); @(posedge CLK); #2;
    ASYNC_RST = 1'b1;
    tick();

    START = 1'b1; NUM_VECTORS = 5'(MK); IN_VALID = 1'b1;
    hs = 0; done_c = -1;
    for (int c = 0; c < 60; c++) begin
      if (c == 1) START = 1'b0;
      IN_DATA = vec(c);
      #1;
      if (IN_VALID && IN_READY) hs++;
      if (DONE) begin
        done_c = c;
        break;
      end
      tick();
    end
    chk("t6_handshakes", hs, MK);
    chk("t6_done_cycle", done_c, 25);
    tick();
    #1;
    chk("t6_idle", BUSY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
